mfcc_frame_buffer: RTL and testbench
====================================

Name: mfcc_frame_buffer

Overview:
- Parametrised, frame-atomic output stage for the MFCC pipeline; successor to the plain one-cycle output register at the end of the accelerator.
- Collects the DCT coefficient stream into frames of a configurable coefficient count and buffers whole frames in a circular RAM.
- Replays each frame to the downstream consumer over a ready/valid interface, with start-of-frame and end-of-frame markers.
- Drops whole frames on overflow, never partial ones, and reports drops through status outputs.

Parameters:
- DATA_W, 32, coefficient width in bits.
- MAX_COEFFS, 32, largest allowed frame length in coefficients.
- DEPTH_WORDS, 128, buffer depth in words; must be a power of two and at least MAX_COEFFS.
- CNT_W, 16, width of the drop counter.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of buffer and partial frame; same effect as rst.
- num_mfcc_coeffs  in  8  frame length; latched at the first coefficient of each frame.
- in_data  in  DATA_W  coefficient from DCT stage.
- in_valid  in  1  in_data valid; no backpressure upstream, every valid cycle is consumed.
- out_data  out  DATA_W  buffered coefficient.
- out_valid  out  1  out_data/out_sop/out_eop valid.
- out_ready  in  1  consumer accepts when out_valid&&out_ready.
- out_sop  out  1  first coefficient of a frame.
- out_eop  out  1  last coefficient of a frame.
- level  out  $clog2(DEPTH_WORDS)+1  committed, not-yet-read words.
- overflow  out  1  sticky: at least one frame dropped.
- drop_count  out  CNT_W  dropped frames, saturating.

Behaviour:
- Reset/flush: every output, pointer and counter goes to 0; the partial frame is discarded.
  - rst or flush asserted mid-frame or mid-readout loses all data.
  - The next in_valid is treated as the first coefficient of a new frame.
- Length latch, applied when coeff_idx==0 and in_valid:
  - len = clamp(num_mfcc_coeffs, 1, MAX_COEFFS); 0 maps to 1, values above MAX_COEFFS map to MAX_COEFFS.
  - Changing num_mfcc_coeffs mid-frame has no effect until the next frame.
- Admission, decided at the first coefficient:
  - free = DEPTH_WORDS - level - words pending in the current write frame.
  - If free < len, the frame is marked DROP: all len coefficients are discarded, drop_count increments once (saturates at 2^CNT_W-1), and overflow sets.
  - Otherwise the frame is marked ACCEPT.
- Write side states: IDLE (coeff_idx==0) -> FILL on the first in_valid.
  - In FILL, coeff_idx advances on each in_valid; on coeff_idx==len-1 the state returns to IDLE.
  - On return from an ACCEPT frame, the frame is committed.
- RAM contents: each word stores {sop, eop, data}; sop=1 at idx 0, eop=1 at idx len-1. For len==1, sop and eop are both 1.
- Commit: the committed write pointer moves forward by len in the cycle after the last coefficient is written, and level increases by len.
  - Uncommitted words are never visible to the read side.
- Read side:
  - One-entry output register in front of the RAM; a registered RAM read feeds it.
  - out_valid rises when the output register holds a word.
  - The register refills when it is empty, or when it is being consumed this cycle, provided committed words remain. This gives sustained 1 word/cycle while out_ready stays high.
  - out_data, out_sop and out_eop are held stable while out_valid && !out_ready.
- Latency: with the buffer empty, the last coefficient of a frame accepted in cycle N gives out_valid=1 with the first word in cycle N+3. The path is commit at N+1, RAM read at N+2, output register at N+3.
- Level: decrements by 1 per handshake. A commit and a handshake in the same cycle give level + len - 1.
- Wrap-around: pointers are modulo DEPTH_WORDS, and frames may straddle the wrap. A full buffer (level==DEPTH_WORDS) is legal; the next frame is dropped.
- Simultaneous drop decision and read: the decision uses the pre-cycle level, so it is conservative.

Test Plan:
- Single frame: num_mfcc_coeffs=13, out_ready=1, 13 valid words 0x100..0x10C -> 13 outputs in order, sop on 0x100, eop on 0x10C, first out_valid 3 cycles after the last input, level returns to 0.
- Backpressure: 4 frames of 13, out_ready toggling 1/0 each cycle -> all 52 words in order, outputs stable while stalled, no drops, overflow=0.
- Overflow: DEPTH_WORDS=128, len=32, out_ready=0, 5 frames -> first 4 committed (level=128), 5th dropped (drop_count=1, overflow=1); then out_ready=1 -> exactly 128 words, frames 1-4 only.
- Clamp/edge: num_mfcc_coeffs=0 -> every output word has sop=eop=1; num_mfcc_coeffs=200 -> frames of 32; change 13->20 mid-frame -> current frame stays 13.
- Wrap: len=24, continuous writes and reads over 20 frames -> data intact across the pointer wrap, sop/eop correct on every frame.
- Flush/reset mid-operation: flush at coefficient 7 of a 13-coefficient frame, with 1 frame buffered -> level=0, out_valid=0 next cycle, overflow/drop_count=0; the next 13 inputs form a clean frame.

Source files
------------

// File: rtl/mfcc_frame_buffer.sv
// Frame-atomic output buffer for the MFCC pipeline: packs DCT coefficients into
// whole frames in a circular RAM and replays them over ready/valid with sop/eop.
module mfcc_frame_buffer #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MAX_COEFFS  = 32,
    parameter int unsigned DEPTH_WORDS = 128,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [7:0]                     num_mfcc_coeffs,
    input  logic [DATA_W-1:0]              in_data,
    input  logic                           in_valid,
    output logic [DATA_W-1:0]              out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_sop,
    output logic                           out_eop,
    output logic [$clog2(DEPTH_WORDS):0]   level,
    output logic                           overflow,
    output logic [CNT_W-1:0]               drop_count
);

    localparam int unsigned AW     = $clog2(DEPTH_WORDS);
    localparam int unsigned PW     = AW + 1;
    localparam int unsigned LEN_W  = $clog2(MAX_COEFFS + 1);
    localparam int unsigned WORD_W = DATA_W + 2;

    typedef enum logic {S_IDLE, S_FILL} wr_state_t;

    wr_state_t          state;
    logic [LEN_W-1:0]   coeff_idx;
    logic [LEN_W-1:0]   len_q;
    logic               drop_q;
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      cmt_ptr;
    logic [PW-1:0]      rd_ptr;
    logic               ram_vld;
    logic [WORD_W-1:0]  ram_q;
    logic [WORD_W-1:0]  mem [DEPTH_WORDS];

    logic [LEN_W-1:0]   len_new;
    logic [LEN_W-1:0]   cur_len;
    logic               admit;
    logic               cur_drop;
    logic               last;
    logic               wr_en;
    logic [WORD_W-1:0]  wr_word;
    logic               commit;
    logic               hs;
    logic               adv;
    logic [PW-1:0]      avail;
    logic               fetch;
    logic [PW-1:0]      level_nxt;

    // Write-side framing, admission and read-side pipeline control
    always_comb begin
        len_new = LEN_W'(num_mfcc_coeffs);
        if (num_mfcc_coeffs == 8'd0) begin
            len_new = LEN_W'(1);
        end else if (32'(num_mfcc_coeffs) > 32'(MAX_COEFFS)) begin
            len_new = LEN_W'(MAX_COEFFS);
        end
        admit     = (32'(level) + 32'(len_new)) <= 32'(DEPTH_WORDS);
        cur_len   = (state == S_IDLE) ? len_new : len_q;
        cur_drop  = (state == S_IDLE) ? !admit : drop_q;
        last      = in_valid && (coeff_idx == cur_len - LEN_W'(1));
        wr_en     = in_valid && !cur_drop;
        wr_word   = {(state == S_IDLE), (coeff_idx == cur_len - LEN_W'(1)), in_data};
        commit    = last && !cur_drop;
        hs        = out_valid && out_ready;
        adv       = !out_valid || out_ready;
        avail     = cmt_ptr - rd_ptr;
        fetch     = (avail != '0) && (!ram_vld || adv);
        level_nxt = level + (commit ? PW'(cur_len) : PW'(0)) - PW'(hs);
    end

    // Frame storage and registered read port; stale contents are never exposed
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wr_word;
        end
        if (fetch) begin
            ram_q <= mem[rd_ptr[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state      <= S_IDLE;
            coeff_idx  <= '0;
            len_q      <= '0;
            drop_q     <= 1'b0;
            wr_ptr     <= '0;
            cmt_ptr    <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
            ram_vld    <= 1'b0;
            out_valid  <= 1'b0;
            out_sop    <= 1'b0;
            out_eop    <= 1'b0;
            out_data   <= '0;
        end else begin
            if (in_valid) begin
                if (last) begin
                    state     <= S_IDLE;
                    coeff_idx <= '0;
                end else begin
                    state     <= S_FILL;
                    coeff_idx <= coeff_idx + LEN_W'(1);
                end
                if (state == S_IDLE) begin
                    len_q  <= len_new;
                    drop_q <= !admit;
                    if (!admit) begin
                        overflow <= 1'b1;
                        if (drop_count != '1) begin
                            drop_count <= drop_count + CNT_W'(1);
                        end
                    end
                end
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            // Publishing the frame end makes the whole frame readable at once
            if (commit) begin
                cmt_ptr <= wr_ptr + PW'(1);
            end
            level <= level_nxt;
            if (fetch) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            ram_vld <= fetch || (ram_vld && !adv);
            if (adv) begin
                out_valid <= ram_vld;
                if (ram_vld) begin
                    {out_sop, out_eop, out_data} <= ram_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_mfcc_frame_buffer.sv
// Directed bench for mfcc_frame_buffer: scoreboard of hand-framed words plus
// explicit status checks for latency, overflow, clamping, wrap and flush.
module tb_mfcc_frame_buffer;

    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic [7:0]        num_mfcc_coeffs;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_sop;
    logic              out_eop;
    logic [7:0]        level;
    logic              overflow;
    logic [15:0]       drop_count;

    int n_vec = 0;
    int n_err = 0;
    int rdy_mode = 0;
    logic [DATA_W+1:0] exp_q[$];

    mfcc_frame_buffer dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .num_mfcc_coeffs (num_mfcc_coeffs),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_sop         (out_sop),
        .out_eop         (out_eop),
        .level           (level),
        .overflow        (overflow),
        .drop_count      (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Ready pattern: 0 = always ready, 1 = toggle every cycle, 2 = stalled
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Every valid output cycle must show the scoreboard head; pop on handshake
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 64'(out_valid), 64'(0));
            end else begin
                check("word", 64'({out_sop, out_eop, out_data}), 64'(exp_q[0]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic send_word(input logic [DATA_W-1:0] d);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int len, input logic [DATA_W-1:0] base, input bit push);
        for (int i = 0; i < len; i++) begin
            if (push) exp_q.push_back({(i == 0), (i == len - 1), base + DATA_W'(i)});
            send_word(base + DATA_W'(i));
        end
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check(tag, 64'(exp_q.size()), 64'(0));
        repeat (4) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        num_mfcc_coeffs = 8'd13;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_level", 64'(level), 64'(0));
        check("rst_overflow", 64'(overflow), 64'(0));
        check("rst_drops", 64'(drop_count), 64'(0));

        // Single frame and first-word latency
        for (int i = 0; i < 12; i++) begin
            exp_q.push_back({(i == 0), 1'b0, 32'h100 + 32'(i)});
            send_word(32'h100 + 32'(i));
        end
        exp_q.push_back({1'b0, 1'b1, 32'h10C});
        in_data = 32'h10C;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("lat_level_commit", 64'(level), 64'(13));
        check("lat_n1_valid", 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;
        check("lat_n2_valid", 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;
        check("lat_n3_valid", 64'(out_valid), 64'(1));
        drain("single_drain");
        check("single_level", 64'(level), 64'(0));

        // Backpressure: four frames with ready toggling
        rdy_mode = 1;
        for (int f = 0; f < 4; f++) send_frame(13, 32'h200 + 32'(f * 16), 1'b1);
        drain("bp_drain");
        rdy_mode = 0;
        check("bp_overflow", 64'(overflow), 64'(0));
        check("bp_drops", 64'(drop_count), 64'(0));
        check("bp_level", 64'(level), 64'(0));

        // Overflow: four frames of 32 fill the buffer, the fifth is dropped
        rdy_mode = 2;
        num_mfcc_coeffs = 8'd32;
        repeat (2) @(posedge clk);
        #1;
        for (int f = 0; f < 5; f++) send_frame(32, 32'h300 + 32'(f * 32), f < 4);
        repeat (3) @(posedge clk);
        #1;
        check("ovf_level", 64'(level), 64'(128));
        check("ovf_drops", 64'(drop_count), 64'(1));
        check("ovf_flag", 64'(overflow), 64'(1));
        rdy_mode = 0;
        drain("ovf_drain");
        check("ovf_level_empty", 64'(level), 64'(0));

        // Clamp: 0 gives single-word frames, 200 gives frames of 32
        num_mfcc_coeffs = 8'd0;
        for (int f = 0; f < 4; f++) send_frame(1, 32'h400 + 32'(f), 1'b1);
        num_mfcc_coeffs = 8'd200;
        for (int f = 0; f < 2; f++) send_frame(32, 32'h500 + 32'(f * 32), 1'b1);
        // Length change mid-frame only affects the following frame
        num_mfcc_coeffs = 8'd13;
        for (int i = 0; i < 13; i++) exp_q.push_back({(i == 0), (i == 12), 32'h600 + 32'(i)});
        for (int i = 0; i < 13; i++) begin
            if (i == 5) num_mfcc_coeffs = 8'd20;
            send_word(32'h600 + 32'(i));
        end
        send_frame(20, 32'h620, 1'b1);
        drain("clamp_drain");
        check("clamp_drops", 64'(drop_count), 64'(1));

        // Wrap: 20 frames of 24 streamed continuously
        num_mfcc_coeffs = 8'd24;
        for (int f = 0; f < 20; f++) send_frame(24, 32'h1000 + 32'(f * 32), 1'b1);
        drain("wrap_drain");
        check("wrap_drops", 64'(drop_count), 64'(1));
        check("wrap_level", 64'(level), 64'(0));

        // Flush at coefficient 7 with one frame buffered
        rdy_mode = 2;
        num_mfcc_coeffs = 8'd13;
        repeat (2) @(posedge clk);
        #1;
        send_frame(13, 32'h700, 1'b1);
        send_frame(7, 32'h720, 1'b0);
        in_data = 32'h727;
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush = 1'b0;
        exp_q.delete();
        check("flush_level", 64'(level), 64'(0));
        check("flush_valid", 64'(out_valid), 64'(0));
        check("flush_overflow", 64'(overflow), 64'(0));
        check("flush_drops", 64'(drop_count), 64'(0));
        rdy_mode = 0;
        send_frame(13, 32'h800, 1'b1);
        drain("flush_drain");
        check("flush_level_end", 64'(level), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
